// File: rtl/demo_key_driver.sv
// Attract-mode keycode source: passes USB keys through, and after a long idle
// period launches the game itself, dodges the stone, and restarts after game over.
module demo_key_driver #(
  parameter int IDLE_FRAMES    = 600,
  parameter int RESTART_FRAMES = 120,
  parameter int HOLD_FRAMES    = 8,
  parameter int SAFE_MARGIN    = 24,
  parameter int THREAT_Y       = 160,
  parameter int CENTER_X       = 320,
  parameter int LANE_MIN       = 80,
  parameter int LANE_MAX       = 560
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] usb_keycode,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  input  logic [9:0] StoneX,
  input  logic [9:0] StoneY,
  input  logic [9:0] Stone_size,
  input  logic       game_over,
  output logic [7:0] keycode,
  output logic       demo_active
);

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_START = 8'h28;
  localparam logic [7:0] KEY_RESET = 8'h2C;

  localparam int IDLE_W = $clog2(IDLE_FRAMES + 1);
  localparam int REST_W = $clog2(RESTART_FRAMES + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [2:0] {
    MANUAL,
    D_CLEAR,
    D_LAUNCH,
    D_PLAY,
    D_OVER
  } state_t;

  state_t              state;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [REST_W-1:0]   rest_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [7:0]          hold_dir;

  logic [10:0] dx, dy, adx, left_edge, right_edge;
  logic [11:0] reach;
  logic        threat, left_blocked, right_blocked;
  logic [7:0]  dodge_dir, centre_key;
  logic [7:0]  steer_key, steer_dir;
  logic [HOLD_W-1:0] steer_hold;

  // Geometry: 10-bit inputs zero-extended, reach widened so it can never wrap.
  always_comb begin
    dx         = {1'b0, StoneX} - {1'b0, BallX};
    dy         = {1'b0, BallY} - {1'b0, StoneY};
    adx        = dx[10] ? (~dx + 11'd1) : dx;
    reach      = {2'b00, BallS} + {2'b00, Stone_size} + 12'(SAFE_MARGIN);
    threat     = !dy[10] && (dy <= 11'(THREAT_Y)) && ({1'b0, adx} < reach);
    left_edge  = {1'b0, BallX} - {1'b0, BallS};
    right_edge = {1'b0, BallX} + {1'b0, BallS};
    left_blocked  = (BallX < BallS) || (left_edge <= 11'(LANE_MIN + 8));
    right_blocked = (right_edge >= 11'(LANE_MAX - 8));
    if (dx[10]) dodge_dir = right_blocked ? KEY_LEFT : KEY_RIGHT;
    else        dodge_dir = left_blocked ? KEY_RIGHT : KEY_LEFT;
    if ({1'b0, BallX} > 11'(CENTER_X + 8))      centre_key = KEY_LEFT;
    else if ({1'b0, BallX} < 11'(CENTER_X - 8)) centre_key = KEY_RIGHT;
    else                                        centre_key = KEY_NONE;
  end

  // A running hold wins over any fresh threat; a new dodge latches its direction.
  always_comb begin
    steer_key  = centre_key;
    steer_dir  = hold_dir;
    steer_hold = hold_cnt;
    if (hold_cnt != '0) begin
      steer_key  = hold_dir;
      steer_hold = hold_cnt - HOLD_W'(1);
    end else if (threat) begin
      steer_key  = dodge_dir;
      steer_dir  = dodge_dir;
      steer_hold = HOLD_W'(HOLD_FRAMES - 1);
    end
  end

  // Outputs are registered with the value belonging to the state being entered.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state       <= MANUAL;
      keycode     <= KEY_NONE;
      demo_active <= 1'b0;
      idle_cnt    <= '0;
      rest_cnt    <= '0;
      hold_cnt    <= '0;
      hold_dir    <= KEY_NONE;
    end else if (usb_keycode != KEY_NONE) begin
      state       <= MANUAL;
      keycode     <= usb_keycode;
      demo_active <= 1'b0;
      idle_cnt    <= '0;
      rest_cnt    <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        MANUAL: begin
          keycode     <= usb_keycode;
          demo_active <= 1'b0;
          if (idle_cnt != IDLE_W'(IDLE_FRAMES)) idle_cnt <= idle_cnt + IDLE_W'(1);
          if (idle_cnt == IDLE_W'(IDLE_FRAMES - 1)) begin
            state       <= D_CLEAR;
            keycode     <= KEY_RESET;
            demo_active <= 1'b1;
          end
        end
        D_CLEAR: begin
          state       <= D_LAUNCH;
          keycode     <= KEY_START;
          demo_active <= 1'b1;
          hold_cnt    <= '0;
          rest_cnt    <= '0;
        end
        D_LAUNCH: begin
          state       <= D_PLAY;
          keycode     <= steer_key;
          demo_active <= 1'b1;
          hold_cnt    <= steer_hold;
          hold_dir    <= steer_dir;
        end
        D_PLAY: begin
          demo_active <= 1'b1;
          if (game_over) begin
            state    <= D_OVER;
            keycode  <= KEY_NONE;
            hold_cnt <= '0;
            rest_cnt <= '0;
          end else begin
            keycode  <= steer_key;
            hold_cnt <= steer_hold;
            hold_dir <= steer_dir;
          end
        end
        D_OVER: begin
          demo_active <= 1'b1;
          if (rest_cnt == REST_W'(RESTART_FRAMES - 1)) begin
            state    <= D_CLEAR;
            keycode  <= KEY_RESET;
            rest_cnt <= '0;
          end else begin
            keycode  <= KEY_NONE;
            rest_cnt <= rest_cnt + REST_W'(1);
          end
        end
        default: begin
          state       <= MANUAL;
          keycode     <= KEY_NONE;
          demo_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demo_key_driver.sv
// Bench for demo_key_driver: directed scenarios plus randomized play, each frame
// compared against a frame-level behavioural model of the attract mode.
module tb_demo_key_driver;

  localparam int IDLE_FRAMES    = 600;
  localparam int RESTART_FRAMES = 120;
  localparam int HOLD_FRAMES    = 8;
  localparam int SAFE_MARGIN    = 24;
  localparam int THREAT_Y       = 160;
  localparam int CENTER_X       = 320;
  localparam int LANE_MIN       = 80;
  localparam int LANE_MAX       = 560;

  localparam int PH_MANUAL = 0;
  localparam int PH_CLEAR  = 1;
  localparam int PH_LAUNCH = 2;
  localparam int PH_PLAY   = 3;
  localparam int PH_OVER   = 4;

  // clock / reset
  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] usb_keycode;
  logic [9:0] BallX, BallY, BallS, StoneX, StoneY, Stone_size;
  logic       game_over;
  logic [7:0] keycode;
  logic       demo_active;

  always #5 frame_clk = ~frame_clk;

  demo_key_driver #(
    .IDLE_FRAMES(IDLE_FRAMES), .RESTART_FRAMES(RESTART_FRAMES),
    .HOLD_FRAMES(HOLD_FRAMES), .SAFE_MARGIN(SAFE_MARGIN),
    .THREAT_Y(THREAT_Y), .CENTER_X(CENTER_X),
    .LANE_MIN(LANE_MIN), .LANE_MAX(LANE_MAX)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .usb_keycode(usb_keycode),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .StoneX(StoneX), .StoneY(StoneY), .Stone_size(Stone_size),
    .game_over(game_over), .keycode(keycode), .demo_active(demo_active)
  );

  // reference model: phase plus frame counts since the relevant event
  int         phase = PH_MANUAL;
  int         zero_run = 0;
  int         over_frames = 0;
  int         hold_left = 0;
  logic [7:0] held_dir = 8'h00;
  logic [7:0] exp_key = 8'h00;
  logic       exp_demo = 1'b0;

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic model_steer();
    int dx, dy, reach, adx;
    dx    = int'(StoneX) - int'(BallX);
    dy    = int'(BallY) - int'(StoneY);
    reach = int'(BallS) + int'(Stone_size) + SAFE_MARGIN;
    adx   = (dx < 0) ? -dx : dx;
    if (hold_left > 0) begin
      exp_key = held_dir;
      hold_left--;
    end else if (dy >= 0 && dy <= THREAT_Y && adx < reach) begin
      if (dx >= 0) held_dir = (int'(BallX) - int'(BallS) <= LANE_MIN + 8) ? 8'h07 : 8'h04;
      else         held_dir = (int'(BallX) + int'(BallS) >= LANE_MAX - 8) ? 8'h04 : 8'h07;
      exp_key   = held_dir;
      hold_left = HOLD_FRAMES - 1;
    end else if (int'(BallX) > CENTER_X + 8) exp_key = 8'h04;
    else if (int'(BallX) < CENTER_X - 8)     exp_key = 8'h07;
    else                                     exp_key = 8'h00;
  endtask

  task automatic model_edge();
    if (Reset) begin
      phase = PH_MANUAL; zero_run = 0; over_frames = 0; hold_left = 0;
      held_dir = 8'h00; exp_key = 8'h00; exp_demo = 1'b0;
    end else if (usb_keycode != 8'h00) begin
      phase = PH_MANUAL; zero_run = 0; hold_left = 0;
      exp_key = usb_keycode; exp_demo = 1'b0;
    end else begin
      zero_run++;
      exp_demo = 1'b1;
      case (phase)
        PH_MANUAL: begin
          if (zero_run == IDLE_FRAMES) begin
            phase = PH_CLEAR; exp_key = 8'h2C;
          end else begin
            exp_key = 8'h00; exp_demo = 1'b0;
          end
        end
        PH_CLEAR: begin phase = PH_LAUNCH; exp_key = 8'h28; hold_left = 0; end
        PH_LAUNCH: begin phase = PH_PLAY; model_steer(); end
        PH_PLAY: begin
          if (game_over) begin
            phase = PH_OVER; exp_key = 8'h00; over_frames = 1; hold_left = 0;
          end else model_steer();
        end
        default: begin
          if (over_frames == RESTART_FRAMES) begin
            phase = PH_CLEAR; exp_key = 8'h2C;
          end else begin
            over_frames++; exp_key = 8'h00;
          end
        end
      endcase
    end
  endtask

  // driver / scoreboard
  task automatic step(input string tag);
    logic [8:0] got, want;
    @(posedge frame_clk);
    model_edge();
    exp_q.push_back({exp_demo, exp_key});
    #1;
    got  = {demo_active, keycode};
    want = exp_q.pop_front();
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_const(input string tag, input logic [8:0] want);
    logic [8:0] got;
    got = {demo_active, keycode};
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic set_ball(input int x, input int y, input int s);
    BallX = 10'(x); BallY = 10'(y); BallS = 10'(s);
  endtask

  task automatic set_stone(input int x, input int y, input int s);
    StoneX = 10'(x); StoneY = 10'(y); Stone_size = 10'(s);
  endtask

  task automatic rand_field();
    int bx, by, sx, sy;
    bx = int'($urandom_range(60, 580));
    if ($urandom_range(0, 19) == 0) bx = int'($urandom_range(0, 30));
    by = int'($urandom_range(300, 460));
    sx = bx + int'($urandom_range(0, 160)) - 80;
    if (sx < 0) sx = 0;
    sy = by - (int'($urandom_range(0, 240)) - 40);
    if (sy < 0) sy = 0;
    set_ball(bx, by, int'($urandom_range(0, 40)));
    set_stone(sx, sy, int'($urandom_range(4, 40)));
  endtask

  task automatic idle_to_demo(input string tag);
    for (int i = 1; i < IDLE_FRAMES; i++) step(tag);
    check_const({tag, "_last_idle"}, 9'h000);
    step(tag);
    check_const({tag, "_clear"}, 9'h12C);
    step(tag);
    check_const({tag, "_launch"}, 9'h128);
  endtask

  task automatic drain(input int n);
    set_stone(int'(BallX), 0, 20);
    for (int i = 0; i < n; i++) step("drain");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; usb_keycode = 8'h00; game_over = 1'b0;
    set_ball(320, 390, 16);
    set_stone(320, 0, 20);
    step("reset");
    step("reset");
    check_const("reset_state", 9'h000);
    Reset = 1'b0;

    idle_to_demo("boot");

    // dodge left, held for the full hold even after the stone crosses over
    set_ball(320, 390, 16);
    set_stone(330, 300, 20);
    for (int f = 1; f <= HOLD_FRAMES; f++) begin
      if (f == 3) StoneX = 10'd300;
      step("hold");
      check_const("hold_left", 9'h104);
    end
    step("redodge");
    check_const("redodge_right", 9'h107);
    drain(HOLD_FRAMES);

    set_ball(100, 390, 16);
    set_stone(110, 300, 20);
    step("wall_left");
    check_const("wall_left_flip", 9'h107);
    drain(HOLD_FRAMES);

    set_ball(10, 390, 20);
    set_stone(15, 300, 20);
    step("underflow");
    check_const("underflow_flip", 9'h107);
    drain(HOLD_FRAMES);

    set_ball(540, 390, 16);
    set_stone(530, 300, 20);
    step("wall_right");
    check_const("wall_right_flip", 9'h104);
    drain(HOLD_FRAMES);

    set_ball(400, 390, 16);
    set_stone(400, 0, 20);
    step("centre_right");
    check_const("recentre_left", 9'h104);
    BallX = 10'd325;
    step("centre_dead");
    check_const("recentre_none", 9'h100);

    // game over -> restart pause -> relaunch, game_over ignored while relaunching
    game_over = 1'b1;
    step("go_entry");
    check_const("go_entry", 9'h100);
    game_over = 1'b0;
    for (int i = 1; i < RESTART_FRAMES; i++) step("go_wait");
    check_const("go_wait_end", 9'h100);
    game_over = 1'b1;
    step("go_clear");
    check_const("go_clear", 9'h12C);
    step("go_launch");
    check_const("go_launch", 9'h128);
    step("go_ignored");
    game_over = 1'b0;
    for (int i = 0; i < 5; i++) step("play");

    game_over = 1'b1;
    step("over_again");
    game_over = 1'b0;
    for (int i = 0; i < 5; i++) step("over_wait");
    usb_keycode = 8'h07;
    game_over = 1'b1;
    step("preempt");
    check_const("preempt", 9'h007);
    usb_keycode = 8'h00;
    game_over = 1'b0;
    idle_to_demo("reidle");

    // reset in the middle of a dodge hold
    set_ball(320, 390, 16);
    set_stone(330, 300, 20);
    step("pre_reset");
    check_const("pre_reset_dodge", 9'h104);
    step("pre_reset");
    Reset = 1'b1;
    step("reset_mid");
    check_const("reset_mid", 9'h000);
    Reset = 1'b0;
    idle_to_demo("post_reset");

    // randomized play with occasional game over and player keys
    for (int i = 0; i < 1500; i++) begin
      rand_field();
      game_over   = ($urandom_range(0, 79) == 0);
      usb_keycode = ($urandom_range(0, 299) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
